riscv_wb_arbiter: RTL and testbench
===================================

Name: riscv_wb_arbiter

Overview:
- Two-master to one-slave arbiter for the core's pipelined Wishbone bus.
- Masters:
  - Master 0 is the load/store unit (data).
  - Master 1 is the instruction fetch unit.
- The grant is registered and locked for as long as the owner holds cyc.
- A bus watchdog terminates transactions that never receive ack or err.

Parameters:
- ROUND_ROBIN, 0: 0 = fixed priority, master 0 wins ties. 1 = on a tie, the master not granted last wins.
- TIMEOUT_CYCLES, 255: cycles without ack/err before a forced error. 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- m_cyc_i  in  2  per-master cyc; bit i = master i.
- m_stb_i  in  2  per-master stb.
- m_we_i  in  2  per-master write enable.
- m_addr_i  in  60  word addresses; master i occupies [30i+29:30i].
- m_sel_i  in  8  byte selects; master i occupies [4i+3:4i].
- m_data_i  in  64  write data; master i occupies [32i+31:32i].
- m_data_o  out  32  read data, s_data_i broadcast to both masters.
- m_ack_o  out  2  per-master ack.
- m_err_o  out  2  per-master err.
- m_stall_o  out  2  per-master stall.
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave stb.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  30  slave word address.
- s_sel_o  out  4  slave byte select.
- s_data_o  out  32  slave write data.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_stall_i  in  1  slave stall.

Behaviour:
- State:
  - grant_q ∈ {NONE, M0, M1}.
  - last_q: last granted master.
  - tcnt_q: watchdog counter, width clog2(TIMEOUT_CYCLES+1).
- Reset (asynchronous):
  - grant_q=NONE, last_q=M1, tcnt_q=0.
  - Output values: s_cyc_o=s_stb_o=s_we_o=0; s_addr_o/s_sel_o/s_data_o=0; m_ack_o=m_err_o=0; m_stall_o=2'b11.
- Output muxing is combinational from grant_q.
  - grant NONE: slave outputs are all 0; m_stall_o=11; m_ack_o=m_err_o=00.
  - grant Mi: s_cyc/stb/we/addr/sel/data are copies of master i's signals.
    - m_ack_o[i]=s_ack_i, m_err_o[i]=s_err_i, m_stall_o[i]=s_stall_i.
    - The other master sees stall=1, ack=0, err=0.
- m_data_o = s_data_i at all times.
- Release condition at each clock edge: grant_q==NONE, OR the owner's m_cyc_i==0, OR a timeout is firing this cycle.
- Arbitration happens only when the release condition is true:
  - Requests are req = m_cyc_i, with the timed-out master masked during its timeout edge.
  - Neither requesting -> NONE.
  - One requesting -> that master.
  - Both requesting:
    - ROUND_ROBIN=0 -> M0.
    - ROUND_ROBIN=1 -> the master != last_q.
  - last_q is updated on every grant.
  - Handoff needs no idle cycle: the owner drops cyc at edge N, so the new owner drives the slave from cycle N+1.
- Latency: a master raising cyc at cycle N while the bus is free is granted at edge N+1. It sees stall=1 during cycle N and must hold stb and its request.
- Grant is held while the owner keeps cyc high, including across multiple stb beats and outstanding acks. A higher-priority request never preempts.
- Watchdog (TIMEOUT_CYCLES>0):
  - tcnt_q clears to 0 on any grant change, and in any cycle with s_ack_i or s_err_i.
  - Otherwise tcnt_q increments each cycle the grant is held.
  - When tcnt_q==TIMEOUT_CYCLES, that cycle:
    - m_err_o[owner]=1.
    - s_cyc_o=s_stb_o=0.
    - Slave ack/err is not forwarded.
    - The grant is released at the closing edge.
  - The owner must drop cyc on err. If it keeps cyc high, it re-arbitrates normally from the following edge.
- Simultaneous ack and drop of cyc by the owner in the same cycle: the ack is forwarded and the grant is released at that edge.
- The slave's s_ack_i/s_err_i while grant is NONE is ignored.
- Reset asserted mid-transaction: s_cyc_o drops immediately (asynchronously). Masters are expected to be reset by the same reset_ni.

Test Plan:
- Single master: m_cyc_i=01 at cycle 0, read addr 0x10, slave acks at cycle 3 with 0xDEADBEEF.
  - s_cyc_o=1 from cycle 1.
  - m_ack_o=01 at cycle 3, m_data_o=0xDEADBEEF.
  - Grant returns to NONE one edge after cyc drops.
- Tie, ROUND_ROBIN=0: m_cyc_i=11 from idle -> M0 granted. M1 stall=1 until M0 drops cyc, then M1 is granted at the very next edge with no idle cycle.
- Tie, ROUND_ROBIN=1, both masters issue continuous single-beat transactions -> grants alternate M0, M1, M0, M1 over 4 transactions.
- Lock: M1 owns the bus with 3 pipelined stb beats, and M0 requests mid-burst -> M0 is not granted until all 3 M1 acks arrive and M1 drops cyc.
- Timeout, TIMEOUT_CYCLES=4: M0 granted, slave never acks.
  - Exactly one m_err_o=01 pulse, on the 5th cycle of the grant, with s_cyc_o=0 in that cycle.
  - A waiting M1 is granted at the next edge.
- Async reset asserted while M0 owns the bus -> s_cyc_o=0 and m_stall_o=11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_arbiter_if
// Purpose  : Signal bundle for the two-master / one-slave pipelined Wishbone
//            arbiter. It carries the packed per-master request buses, the
//            per-master responses and the single slave-side bus.
// Modports :
//   master : arbiter view. It drives the slave bus and the master responses,
//            and samples the master requests and the slave responses.
//   slave  : environment view. The masters and the slave device drive the
//            requests and responses, and sample what the arbiter drives.
// Signals  :
//   m_cyc_i/m_stb_i/m_we_i [1:0]  per-master cyc/stb/we, bit i = master i
//   m_addr_i [59:0]               word address, master i at [30i+29:30i]
//   m_sel_i  [7:0]                byte selects, master i at [4i+3:4i]
//   m_data_i [63:0]               write data, master i at [32i+31:32i]
//   m_data_o [31:0]               read data broadcast to both masters
//   m_ack_o/m_err_o/m_stall_o     per-master responses
//   s_*_o                         slave request bus
//   s_data_i/s_ack_i/s_err_i/s_stall_i  slave responses
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_wb_arbiter_if;
  logic [1:0]  m_cyc_i;
  logic [1:0]  m_stb_i;
  logic [1:0]  m_we_i;
  logic [59:0] m_addr_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_data_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;
  logic [1:0]  m_stall_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [29:0] s_addr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;
  logic        s_err_i;
  logic        s_stall_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    input  s_data_i, s_ack_i, s_err_i, s_stall_i,
    output m_data_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_data_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    output s_data_i, s_ack_i, s_err_i, s_stall_i,
    input  m_data_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_data_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_arbiter
// Purpose  : Arbitrates the load/store unit (master 0) and the instruction
//            fetch unit (master 1) onto one pipelined Wishbone slave. The
//            grant is registered and held for as long as the owner keeps
//            cyc high. A watchdog forces an error on the owner when the
//            slave goes TIMEOUT_CYCLES cycles without ack or err.
// Params   :
//   ROUND_ROBIN    0 = fixed priority (master 0 wins ties),
//                  1 = on a tie the master not granted last wins
//   TIMEOUT_CYCLES cycles without ack/err before a forced error, 0 = off
// Ports    :
//   clk_i     clock
//   reset_ni  asynchronous active-low reset
//   bus       riscv_wb_arbiter_if.master (masters' and slave's buses)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_wb_arbiter #(
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  riscv_wb_arbiter_if.master bus
);

  // Watchdog counter width; kept at one bit when the watchdog is disabled.
  localparam int c_TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_TCNT_W-1:0] c_TCNT_LIMIT = c_TCNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } grant_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  grant_e              r_grant;
  logic                r_last;   // last granted master: 0 = M0, 1 = M1
  logic [c_TCNT_W-1:0] r_tcnt;

  grant_e              w_grant_nxt;
  logic                w_last_nxt;
  logic [c_TCNT_W-1:0] w_tcnt_nxt;

  // --------------------------------------------------------------------------
  // Decoded grant and owner view
  // --------------------------------------------------------------------------
  logic        w_owned;      // some master holds the bus
  logic        w_own;        // index of the owner when w_owned
  logic        w_owner_cyc;
  logic        w_owner_stb;
  logic        w_owner_we;
  logic [29:0] w_owner_addr;
  logic [3:0]  w_owner_sel;
  logic [31:0] w_owner_data;
  logic        w_timeout;
  logic        w_release;
  logic [1:0]  w_req;

  assign w_owned      = (r_grant != GNT_NONE);
  assign w_own        = (r_grant == GNT_M1);
  assign w_owner_cyc  = w_own ? bus.m_cyc_i[1]        : bus.m_cyc_i[0];
  assign w_owner_stb  = w_own ? bus.m_stb_i[1]        : bus.m_stb_i[0];
  assign w_owner_we   = w_own ? bus.m_we_i[1]         : bus.m_we_i[0];
  assign w_owner_addr = w_own ? bus.m_addr_i[59:30]   : bus.m_addr_i[29:0];
  assign w_owner_sel  = w_own ? bus.m_sel_i[7:4]      : bus.m_sel_i[3:0];
  assign w_owner_data = w_own ? bus.m_data_i[63:32]   : bus.m_data_i[31:0];

  // The watchdog fires in the cycle the counter reaches the limit; that same
  // cycle kills the slave strobe and releases the grant at its closing edge.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_owned && (r_tcnt == c_TCNT_LIMIT);
  assign w_release = !w_owned || !w_owner_cyc || w_timeout;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_grant <= GNT_NONE;
      r_last  <= 1'b1;
      r_tcnt  <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: arbitration and watchdog
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_tcnt_nxt  = r_tcnt;
    w_req       = 2'b00;

    if (w_release) begin
      w_req = bus.m_cyc_i;
      // A master that just timed out sits out one arbitration round so the
      // other master can take the bus at the very next edge.
      if (w_timeout) begin
        w_req[w_own] = 1'b0;
      end
      unique case (w_req)
        2'b01:   w_grant_nxt = GNT_M0;
        2'b10:   w_grant_nxt = GNT_M1;
        2'b11: begin
          if ((ROUND_ROBIN != 0) && (r_last == 1'b0)) begin
            w_grant_nxt = GNT_M1;
          end else begin
            w_grant_nxt = GNT_M0;
          end
        end
        default: w_grant_nxt = GNT_NONE;
      endcase
      if (w_grant_nxt != GNT_NONE) begin
        w_last_nxt = (w_grant_nxt == GNT_M1);
      end
    end

    // Count idle-response cycles of the current owner; any grant change or
    // slave response restarts the count.
    if ((TIMEOUT_CYCLES == 0) || !w_owned || (w_grant_nxt != r_grant) ||
        bus.s_ack_i || bus.s_err_i) begin
      w_tcnt_nxt = '0;
    end else begin
      w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output mux, purely from the registered grant so reset clears it at once
  // --------------------------------------------------------------------------
  logic        w_s_cyc;
  logic        w_s_stb;
  logic        w_s_we;
  logic [29:0] w_s_addr;
  logic [3:0]  w_s_sel;
  logic [31:0] w_s_data;
  logic [1:0]  w_m_ack;
  logic [1:0]  w_m_err;
  logic [1:0]  w_m_stall;

  always_comb begin
    w_s_cyc   = 1'b0;
    w_s_stb   = 1'b0;
    w_s_we    = 1'b0;
    w_s_addr  = '0;
    w_s_sel   = '0;
    w_s_data  = '0;
    w_m_ack   = 2'b00;
    w_m_err   = 2'b00;
    w_m_stall = 2'b11;

    if (w_owned) begin
      w_s_cyc          = w_owner_cyc & ~w_timeout;
      w_s_stb          = w_owner_stb & ~w_timeout;
      w_s_we           = w_owner_we;
      w_s_addr         = w_owner_addr;
      w_s_sel          = w_owner_sel;
      w_s_data         = w_owner_data;
      // On a timeout the slave's own response is swallowed and replaced by
      // the forced error.
      w_m_ack[w_own]   = bus.s_ack_i & ~w_timeout;
      w_m_err[w_own]   = bus.s_err_i | w_timeout;
      w_m_stall[w_own] = bus.s_stall_i;
    end
  end

  assign bus.s_cyc_o   = w_s_cyc;
  assign bus.s_stb_o   = w_s_stb;
  assign bus.s_we_o    = w_s_we;
  assign bus.s_addr_o  = w_s_addr;
  assign bus.s_sel_o   = w_s_sel;
  assign bus.s_data_o  = w_s_data;
  assign bus.m_ack_o   = w_m_ack;
  assign bus.m_err_o   = w_m_err;
  assign bus.m_stall_o = w_m_stall;
  assign bus.m_data_o  = bus.s_data_i;

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_wb_arbiter
// Purpose  : Self-checking bench for riscv_wb_arbiter. Two instances share
//            one stimulus: a fixed-priority one and a round-robin one, both
//            with a watchdog limit of 4. A transaction-level model predicts
//            every output of both instances each cycle; directed scenarios
//            add explicit checks for the key protocol points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_wb_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [59:0] addr;
  logic [7:0]  sel;
  logic [63:0] wdat;
  logic [31:0] sdat;
  logic        sack, serr, sstall;

  riscv_wb_arbiter_if bus_fp ();
  riscv_wb_arbiter_if bus_rr ();

  assign bus_fp.m_cyc_i = cyc;   assign bus_rr.m_cyc_i = cyc;
  assign bus_fp.m_stb_i = stb;   assign bus_rr.m_stb_i = stb;
  assign bus_fp.m_we_i = we;     assign bus_rr.m_we_i = we;
  assign bus_fp.m_addr_i = addr; assign bus_rr.m_addr_i = addr;
  assign bus_fp.m_sel_i = sel;   assign bus_rr.m_sel_i = sel;
  assign bus_fp.m_data_i = wdat; assign bus_rr.m_data_i = wdat;
  assign bus_fp.s_data_i = sdat; assign bus_rr.s_data_i = sdat;
  assign bus_fp.s_ack_i = sack;  assign bus_rr.s_ack_i = sack;
  assign bus_fp.s_err_i = serr;  assign bus_rr.s_err_i = serr;
  assign bus_fp.s_stall_i = sstall; assign bus_rr.s_stall_i = sstall;

  riscv_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(TMO)) u_dut_fp (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus_fp.master));
  riscv_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TMO)) u_dut_rr (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus_rr.master));

  always #5 clk = ~clk;

  // Packed view of all outputs: {s_cyc,s_stb,s_we,s_addr,s_sel,s_data,
  // m_ack,m_err,m_stall,m_data}
  logic [106:0] obs_fp, obs_rr;
  assign obs_fp = {bus_fp.s_cyc_o, bus_fp.s_stb_o, bus_fp.s_we_o, bus_fp.s_addr_o,
                   bus_fp.s_sel_o, bus_fp.s_data_o, bus_fp.m_ack_o, bus_fp.m_err_o,
                   bus_fp.m_stall_o, bus_fp.m_data_o};
  assign obs_rr = {bus_rr.s_cyc_o, bus_rr.s_stb_o, bus_rr.s_we_o, bus_rr.s_addr_o,
                   bus_rr.s_sel_o, bus_rr.s_data_o, bus_rr.m_ack_o, bus_rr.m_err_o,
                   bus_rr.m_stall_o, bus_rr.m_data_o};

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: owner (-1 none), last winner and
  // number of cycles the owner has waited without any slave response.
  int own [2];
  int lst [2];
  int held[2];
  int rr  [2];

  // Values observed in the most recent cycle.
  logic        fp_scyc, rr_scyc;
  logic [1:0]  fp_stall, fp_ack, fp_err, rr_stall;
  logic [31:0] fp_mdata;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; lst[k] = 1; held[k] = 0;
    end
  endtask

  function automatic logic [106:0] expect_out(input int k);
    logic c, s, w;
    logic [29:0] a;
    logic [3:0]  se;
    logic [31:0] d;
    logic [1:0]  ack, err, stall;
    int o;
    bit fire;
    o = own[k];
    c = 1'b0; s = 1'b0; w = 1'b0; a = '0; se = '0; d = '0;
    ack = 2'b00; err = 2'b00; stall = 2'b11;
    if (o >= 0) begin
      fire     = (held[k] == TMO);
      c        = cyc[o] & !fire;
      s        = stb[o] & !fire;
      w        = we[o];
      a        = addr[30*o +: 30];
      se       = sel[4*o +: 4];
      d        = wdat[32*o +: 32];
      ack[o]   = sack & !fire;
      err[o]   = serr | fire;
      stall[o] = sstall;
    end
    return {c, s, w, a, se, d, ack, err, stall, sdat};
  endfunction

  task automatic model_edge(input int k);
    int o, nxt;
    bit fire;
    logic [1:0] req;
    o    = own[k];
    nxt  = o;
    fire = (o >= 0) && (held[k] == TMO);
    if (o < 0 || !cyc[o] || fire) begin
      req = cyc;
      if (fire) req[o] = 1'b0;
      if (req == 2'b11)      nxt = (rr[k] != 0) ? 1 - lst[k] : 0;
      else if (req == 2'b01) nxt = 0;
      else if (req == 2'b10) nxt = 1;
      else                   nxt = -1;
      if (nxt >= 0) lst[k] = nxt;
    end
    if (nxt != o || sack || serr) held[k] = 0;
    else if (o >= 0)              held[k] = held[k] + 1;
    own[k] = nxt;
  endtask

  // One bus cycle: inputs are already applied at the falling edge.
  task automatic cycle(input string tag);
    #1;
    fp_scyc = bus_fp.s_cyc_o;  rr_scyc  = bus_rr.s_cyc_o;
    fp_stall = bus_fp.m_stall_o; rr_stall = bus_rr.m_stall_o;
    fp_ack = bus_fp.m_ack_o; fp_err = bus_fp.m_err_o; fp_mdata = bus_fp.m_data_o;
    chk({tag, "/fp"}, 128'(obs_fp), 128'(expect_out(0)));
    chk({tag, "/rr"}, 128'(obs_rr), 128'(expect_out(1)));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; addr = '0; sel = '0; wdat = '0;
    sdat = '0; sack = 1'b0; serr = 1'b0; sstall = 1'b0;
  endtask

  initial begin
    int win_rr[4];
    int ack1_cnt, err_cnt;
    logic [63:0] r64;

    rr[0] = 0; rr[1] = 1;
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_fp", 128'(obs_fp), 128'({3'b000, 30'd0, 4'd0, 32'd0, 2'b00, 2'b00, 2'b11, 32'd0}));
    chk("reset_rr", 128'(obs_rr), 128'({3'b000, 30'd0, 4'd0, 32'd0, 2'b00, 2'b00, 2'b11, 32'd0}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single master read -------------------------------------------
    cyc = 2'b01; stb = 2'b01; addr[29:0] = 30'h10; sel[3:0] = 4'hF;
    cycle("t1c0"); chk("t1_c0_scyc", 128'(fp_scyc), 128'(1'b0));
    chk("t1_c0_stall", 128'(fp_stall), 128'(2'b11));
    cycle("t1c1"); chk("t1_c1_scyc", 128'(fp_scyc), 128'(1'b1));
    stb = 2'b00;
    cycle("t1c2");
    sack = 1'b1; sdat = 32'hDEADBEEF;
    cycle("t1c3"); chk("t1_c3_ack", 128'(fp_ack), 128'(2'b01));
    chk("t1_c3_data", 128'(fp_mdata), 128'(32'hDEADBEEF));
    sack = 1'b0; sdat = '0; cyc = 2'b00;
    cycle("t1c4");
    cycle("t1c5"); chk("t1_c5_stall", 128'(fp_stall), 128'(2'b11));

    // ---- tie from idle, handoff without idle cycle ----------------------
    cyc = 2'b11; stb = 2'b11; addr = {30'h200, 30'h100};
    cycle("t2c0"); chk("t2_c0_stall", 128'(fp_stall), 128'(2'b11));
    cycle("t2c1"); chk("t2_c1_stall", 128'(fp_stall), 128'(2'b10));
    stb = 2'b10; sack = 1'b1;
    cycle("t2c2"); chk("t2_c2_ack", 128'(fp_ack), 128'(2'b01));
    sack = 1'b0; cyc = 2'b10;
    cycle("t2c3"); chk("t2_c3_stall", 128'(fp_stall), 128'(2'b10));
    cycle("t2c4"); chk("t2_c4_stall", 128'(fp_stall), 128'(2'b01));
    chk("t2_c4_scyc", 128'(fp_scyc), 128'(1'b1));
    sack = 1'b1; stb = 2'b00;
    cycle("t2c5");
    idle_inputs();
    cycle("t2c6"); cycle("t2c7");

    // ---- repeated ties from idle: fixed priority vs round robin -----------
    for (int t = 0; t < 4; t++) begin
      cyc = 2'b11; stb = 2'b11; addr = {30'h3A0 + 30'(t), 30'h1A0 + 30'(t)};
      cycle("t3a");
      sack = 1'b1;
      cycle("t3b");
      win_rr[t] = (rr_stall == 2'b10) ? 0 : ((rr_stall == 2'b01) ? 1 : -1);
      chk("t3_fp_winner", 128'(fp_stall), 128'(2'b10));
      idle_inputs();
      cycle("t3c"); cycle("t3d");
    end
    chk("t3_rr_first", 128'(win_rr[0]), 128'(0));
    for (int t = 1; t < 4; t++)
      chk("t3_rr_alternate", 128'(win_rr[t]), 128'(1 - win_rr[t-1]));

    // ---- grant lock across a 3-beat burst -------------------------------
    ack1_cnt = 0;
    cyc = 2'b10; stb = 2'b10; addr[59:30] = 30'h300;
    cycle("t4c0");
    cycle("t4c1"); chk("t4_c1_stall", 128'(fp_stall), 128'(2'b01));
    addr[59:30] = 30'h301; cyc = 2'b11; stb = 2'b11; sack = 1'b1;
    cycle("t4c2"); chk("t4_c2_stall", 128'(fp_stall), 128'(2'b01));
    ack1_cnt += int'(fp_ack[1]);
    addr[59:30] = 30'h302;
    cycle("t4c3"); ack1_cnt += int'(fp_ack[1]);
    stb = 2'b01;
    cycle("t4c4"); chk("t4_c4_stall", 128'(fp_stall), 128'(2'b01));
    ack1_cnt += int'(fp_ack[1]);
    sack = 1'b0; cyc = 2'b01;
    cycle("t4c5"); chk("t4_c5_stall", 128'(fp_stall), 128'(2'b01));
    cycle("t4c6"); chk("t4_c6_stall", 128'(fp_stall), 128'(2'b10));
    chk("t4_m1_acks", 128'(ack1_cnt), 128'(3));
    sack = 1'b1; stb = 2'b00;
    cycle("t4c7");
    idle_inputs();
    cycle("t4c8"); cycle("t4c9");

    // ---- watchdog timeout with a waiting master ------------------------
    err_cnt = 0;
    cyc = 2'b01; stb = 2'b01; addr = {30'h77, 30'h40};
    cycle("t5c0");
    cyc = 2'b11; stb = 2'b11;
    for (int c = 1; c <= 4; c++) begin
      cycle("t5wait");
      chk("t5_wait_scyc", 128'(fp_scyc), 128'(1'b1));
      err_cnt += (fp_err != 2'b00) ? 1 : 0;
      stb = 2'b10;
    end
    cycle("t5c5");
    chk("t5_c5_err", 128'(fp_err), 128'(2'b01));
    chk("t5_c5_scyc", 128'(fp_scyc), 128'(1'b0));
    err_cnt += (fp_err != 2'b00) ? 1 : 0;
    cyc = 2'b10;
    cycle("t5c6"); chk("t5_c6_stall", 128'(fp_stall), 128'(2'b01));
    err_cnt += (fp_err != 2'b00) ? 1 : 0;
    chk("t5_err_pulses", 128'(err_cnt), 128'(1));
    sack = 1'b1; stb = 2'b00;
    cycle("t5c7");
    idle_inputs();
    cycle("t5c8"); cycle("t5c9");

    // ---- asynchronous reset while M0 owns the bus ----------------------
    cyc = 2'b01; stb = 2'b01; addr[29:0] = 30'h55;
    cycle("t6c0");
    cycle("t6c1"); chk("t6_c1_scyc", 128'(fp_scyc), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_scyc_fp", 128'(bus_fp.s_cyc_o), 128'(1'b0));
    chk("t6_async_stall_fp", 128'(bus_fp.m_stall_o), 128'(2'b11));
    chk("t6_async_scyc_rr", 128'(bus_rr.s_cyc_o), 128'(1'b0));
    chk("t6_async_stall_rr", 128'(bus_rr.m_stall_o), 128'(2'b11));
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized traffic against the model ---------------------------
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(7) == 0) cyc[i] = ~cyc[i];
      stb    = cyc & 2'($urandom_range(3));
      we     = 2'($urandom_range(3));
      r64    = {$urandom(), $urandom()};
      addr   = r64[59:0];
      sel    = 8'($urandom_range(255));
      wdat   = {$urandom(), $urandom()};
      sdat   = $urandom();
      sack   = ($urandom_range(3) == 0);
      serr   = ($urandom_range(15) == 0);
      sstall = ($urandom_range(3) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
